// File: rtl/minc_loader_if.sv
// Instruction-ROM write port driven by minc_loader: one-cycle strobe with address and data.
interface minc_loader_if;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [14:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/minc_loader.sv
// UART (8N1) program loader for the minc core: writes framed 15-bit words into ROM, then releases nRESET.
// Optional trailing checksum byte enabled by defining MINC_LOADER_CSUM_EN.
module minc_loader #(
    parameter int CLK_DIV = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          RXD,
    minc_loader_if.master rom,
    output logic          cpu_nreset,
    output logic          busy,
    output logic          err
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LD_IDLE, LD_COUNT, LD_LO, LD_HI, LD_CSUM, LD_RUN} ld_state_t;

    logic             r_rxd_meta, r_rxd_sync, r_rxd_prev;
    logic             w_rx_fall;
    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift, r_byte;
    logic             r_byte_vld, r_frame_err;

    ld_state_t        r_ld_state;
    logic [7:0]       r_addr, r_left, r_lo;
`ifdef MINC_LOADER_CSUM_EN
    logic [7:0]       r_csum;
`endif
    logic             r_wr_en;
    logic [7:0]       r_wr_addr;
    logic [14:0]      r_wr_data;
    logic             r_cpu_nreset, r_busy, r_err;

    // Sync flops reset high so a line idling high never looks like a start edge after reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
            r_rxd_meta <= RXD;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    assign w_rx_fall = r_rxd_prev & ~r_rxd_sync;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_byte      <= '0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == CNT_HALF) begin
                        r_rx_cnt   <= '0;
                        r_bit_idx  <= '0;
                        r_rx_state <= r_rxd_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == CNT_FULL) begin
                        r_rx_cnt  <= '0;
                        r_shift   <= {r_rxd_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == CNT_FULL) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (r_rxd_sync) begin
                            r_byte     <= r_shift;
                            r_byte_vld <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ld_state   <= LD_IDLE;
            r_addr       <= '0;
            r_left       <= '0;
            r_lo         <= '0;
`ifdef MINC_LOADER_CSUM_EN
            r_csum       <= '0;
`endif
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_cpu_nreset <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
`ifndef MINC_LOADER_CSUM_EN
            // Release lags RUN entry by one cycle so it follows the final write strobe.
            if (r_ld_state == LD_RUN) r_cpu_nreset <= 1'b1;
`endif
            if (r_frame_err) begin
                r_err        <= 1'b1;
                r_ld_state   <= LD_IDLE;
                r_cpu_nreset <= 1'b0;
                r_busy       <= 1'b0;
            end else if (r_byte_vld) begin
                case (r_ld_state)
                    LD_IDLE, LD_RUN: begin
                        if (r_byte == SYNC_BYTE) begin
                            r_err        <= 1'b0;
                            r_addr       <= '0;
                            r_cpu_nreset <= 1'b0;
                            r_busy       <= 1'b1;
                            r_ld_state   <= LD_COUNT;
                        end
                    end
                    LD_COUNT: begin
                        r_left     <= r_byte - 8'd1;
`ifdef MINC_LOADER_CSUM_EN
                        r_csum     <= '0;
`endif
                        r_ld_state <= LD_LO;
                    end
                    LD_LO: begin
                        r_lo       <= r_byte;
`ifdef MINC_LOADER_CSUM_EN
                        r_csum     <= r_csum + r_byte;
`endif
                        r_ld_state <= LD_HI;
                    end
                    LD_HI: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= {r_byte[6:0], r_lo};
                        r_addr    <= r_addr + 8'd1;
`ifdef MINC_LOADER_CSUM_EN
                        r_csum    <= r_csum + r_byte;
`endif
                        if (r_left == 8'd0) begin
`ifdef MINC_LOADER_CSUM_EN
                            r_ld_state <= LD_CSUM;
`else
                            r_ld_state <= LD_RUN;
                            r_busy     <= 1'b0;
`endif
                        end else begin
                            r_left     <= r_left - 8'd1;
                            r_ld_state <= LD_LO;
                        end
                    end
`ifdef MINC_LOADER_CSUM_EN
                    LD_CSUM: begin
                        r_busy <= 1'b0;
                        if (r_byte == r_csum) begin
                            r_cpu_nreset <= 1'b1;
                            r_ld_state   <= LD_RUN;
                        end else begin
                            r_err      <= 1'b1;
                            r_ld_state <= LD_IDLE;
                        end
                    end
`endif
                    default: r_ld_state <= LD_IDLE;
                endcase
            end
        end
    end

    assign rom.wr_en   = r_wr_en;
    assign rom.wr_addr = r_wr_addr;
    assign rom.wr_data = r_wr_data;
    assign cpu_nreset  = r_cpu_nreset;
    assign busy        = r_busy;
    assign err         = r_err;
endmodule

// File: tb/tb_minc_loader.sv
// Self-checking bench for minc_loader: frame-level reference model, randomized images, error cases.
module tb_minc_loader;
    // A short bit period keeps the 256-word image within a modest cycle budget.
    localparam int DIV = 8;
    localparam int LAT = 2 + DIV / 2 + 9 * DIV + 1;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic RXD = 1'b1;
    logic cpu_nreset, busy, err;

    minc_loader_if rom ();

    minc_loader #(.CLK_DIV(DIV)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .RXD       (RXD),
        .rom       (rom),
        .cpu_nreset(cpu_nreset),
        .busy      (busy),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  addr;
        logic [14:0] data;
        int          cyc;
    } wr_t;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    wr_t         wr_q[$];
    logic [15:0] img[$];
    int          nrst_rise = -1;
    int          nrst_fall = -1;
    int          err_rise = -1;
    logic        prev_nrst = 1'b0;
    logic        prev_err = 1'b0;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        wr_t w;
        if (rom.wr_en === 1'b1) begin
            w.addr = rom.wr_addr;
            w.data = rom.wr_data;
            w.cyc  = cyc;
            wr_q.push_back(w);
        end
        if (cpu_nreset === 1'b1 && prev_nrst !== 1'b1) nrst_rise = cyc;
        if (cpu_nreset === 1'b0 && prev_nrst === 1'b1) nrst_fall = cyc;
        if (err === 1'b1 && prev_err !== 1'b1) err_rise = cyc;
        prev_nrst = cpu_nreset;
        prev_err  = err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives one 8N1 character; fall returns the cycle in which the start bit began.
    task automatic send_byte(input logic [7:0] b, input logic stop, output int fall);
        RXD  = 1'b0;
        fall = cyc;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            tick(DIV);
        end
        RXD = stop;
        tick(DIV);
        RXD = 1'b1;
        tick(3);
    endtask

    // Sends the image held in img and checks the outcome the frame rules predict.
    task automatic run_frame(input bit send_sync, input bit bad, input string tag);
        int         f, f_hi, f_ck;
        int         n;
        logic [7:0] sum;
        logic [7:0] nb;
        bit         exp_ok;
        n    = img.size();
        nb   = n[7:0];
        sum  = 8'h00;
        f_hi = 0;
        f_ck = 0;
        wr_q.delete();
        nrst_rise = -1;
        if (send_sync) begin
            send_byte(8'hA5, 1'b1, f);
            check({tag, "_sync_err"}, err, 0);
            check({tag, "_sync_busy"}, busy, 1);
            check({tag, "_sync_nrst"}, cpu_nreset, 0);
        end
        send_byte(nb, 1'b1, f);
        for (int i = 0; i < n; i++) begin
            send_byte(img[i][7:0], 1'b1, f);
            send_byte(img[i][15:8], 1'b1, f);
            if (i == 0) f_hi = f;
            sum = sum + img[i][7:0] + img[i][15:8];
        end
`ifdef MINC_LOADER_CSUM_EN
        send_byte(sum ^ {7'b0, bad}, 1'b1, f_ck);
        exp_ok = !bad;
`else
        exp_ok = 1'b1;
`endif
        tick(2);
        check({tag, "_wr_count"}, wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            check({tag, "_wr_addr"}, wr_q[i].addr, i);
            check({tag, "_wr_data"}, wr_q[i].data, img[i][14:0]);
        end
        if (wr_q.size() > 0) check({tag, "_wr_latency"}, wr_q[0].cyc - f_hi, LAT + 1);
        check({tag, "_err"}, err, !exp_ok);
        check({tag, "_nrst"}, cpu_nreset, exp_ok);
        check({tag, "_busy"}, busy, 0);
        if (exp_ok && wr_q.size() > 0) begin
`ifdef MINC_LOADER_CSUM_EN
            check({tag, "_nrst_timing"}, nrst_rise - f_ck, LAT + 1);
`else
            check({tag, "_nrst_timing"}, nrst_rise, wr_q[wr_q.size()-1].cyc + 1);
`endif
        end
    endtask

    initial begin
        int f, f_bad;
        bit bad;

        // Reset with the line idle.
        RESET = 1'b1;
        RXD   = 1'b1;
        tick(3);
        check("rst_wr_en", rom.wr_en, 0);
        check("rst_wr_addr", rom.wr_addr, 0);
        check("rst_wr_data", rom.wr_data, 0);
        check("rst_nrst", cpu_nreset, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_no_write", wr_q.size(), 0);
        RESET = 1'b0;
        tick(5);

        // Two-word reference frame (checksum C4).
        img = '{16'h1234, 16'h0678};
        run_frame(1'b1, 1'b0, "basic");

`ifdef MINC_LOADER_CSUM_EN
        // Same frame with a wrong checksum, then recovery by a valid frame.
        run_frame(1'b1, 1'b1, "badck");
        run_frame(1'b1, 1'b0, "recover");
`endif

        // Framing error inside a frame, followed by a stray byte.
        wr_q.delete();
        err_rise = -1;
        send_byte(8'hA5, 1'b1, f);
        send_byte(8'h01, 1'b1, f);
        send_byte(8'h34, 1'b1, f);
        send_byte(8'h56, 1'b0, f_bad);
        tick(2);
        check("ferr_err", err, 1);
        check("ferr_timing", err_rise - f_bad, LAT + 1);
        check("ferr_busy", busy, 0);
        check("ferr_nrst", cpu_nreset, 0);
        check("ferr_no_write", wr_q.size(), 0);
        send_byte(8'h12, 1'b1, f);
        tick(2);
        check("ferr_stray_write", wr_q.size(), 0);
        check("ferr_stray_busy", busy, 0);

        // A 4-cycle glitch between lo and hi must not produce a byte.
        wr_q.delete();
        send_byte(8'hA5, 1'b1, f);
        send_byte(8'h01, 1'b1, f);
        send_byte(8'h34, 1'b1, f);
        RXD = 1'b0;
        tick(4);
        RXD = 1'b1;
        tick(20);
        check("glitch_busy", busy, 1);
        check("glitch_no_write", wr_q.size(), 0);
        send_byte(8'h12, 1'b1, f);
`ifdef MINC_LOADER_CSUM_EN
        send_byte(8'h46, 1'b1, f);
`endif
        tick(2);
        check("glitch_wr_count", wr_q.size(), 1);
        if (wr_q.size() > 0) check("glitch_wr_data", wr_q[0].data, 15'h1234);
        check("glitch_nrst", cpu_nreset, 1);
        check("glitch_err", err, 0);

        // In RUN: a non-sync byte is ignored, the sync byte re-enters loading.
        send_byte(8'h55, 1'b1, f);
        tick(2);
        check("run_ignore_nrst", cpu_nreset, 1);
        check("run_ignore_busy", busy, 0);
        nrst_fall = -1;
        send_byte(8'hA5, 1'b1, f);
        check("run_sync_fall", nrst_fall - f, LAT + 1);
        check("run_sync_busy", busy, 1);
        check("run_sync_nrst", cpu_nreset, 0);

        // N=0 means a full 256-word image.
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back(16'($urandom));
        run_frame(1'b0, 1'b0, "n256");
        if (wr_q.size() > 0) check("n256_last_addr", wr_q[wr_q.size()-1].addr, 255);

        // Randomized frames, some with a corrupted checksum.
        for (int k = 0; k < 4; k++) begin
            img.delete();
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) img.push_back(16'($urandom));
            bad = ($urandom_range(0, 2) == 0);
            run_frame(1'b1, bad, "rand");
        end

        // RESET mid-frame aborts loading; later bytes are not written.
        wr_q.delete();
        send_byte(8'hA5, 1'b1, f);
        send_byte(8'h03, 1'b1, f);
        send_byte(8'h34, 1'b1, f);
        send_byte(8'h12, 1'b1, f);
        tick(2);
        RESET = 1'b1;
        tick(2);
        check("midrst_busy", busy, 0);
        check("midrst_nrst", cpu_nreset, 0);
        check("midrst_err", err, 0);
        check("midrst_wr_en", rom.wr_en, 0);
        RESET = 1'b0;
        tick(2);
        send_byte(8'h78, 1'b1, f);
        send_byte(8'h06, 1'b1, f);
        tick(2);
        check("midrst_wr_count", wr_q.size(), 1);
        check("midrst_after_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
